// File: rtl/chaos_loader_pkg.sv
// ============================================================================
// Module  : chaos_loader_pkg
// Brief   : Op codes, FSM encoding and defaults for the chaos chain loader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package chaos_loader_pkg;

    localparam int CW_DEFAULT = 32;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'd0,
        OP_READ   = 2'd1,
        OP_FINISH = 2'd2,
        OP_NOP    = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SHIFT  = 3'd1,
        S_RSP    = 3'd2,
        S_FINISH = 3'd3,
        S_DONE   = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/chaos_offset_counter.sv
// ============================================================================
// Module  : chaos_offset_counter
// Brief   : Modulo-NCELLS shift counter with clear and wrap indication.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module chaos_offset_counter #(
    parameter int NCELLS = 400,
    parameter int AW     = $clog2(NCELLS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_inc,
    input  logic          i_clr,
    output logic [AW-1:0] o_count,
    output logic          o_wrap
);

    localparam logic [AW-1:0] C_LAST = AW'(NCELLS - 1);

    logic [AW-1:0] r_count_q;
    logic [AW-1:0] w_count_d;

    // Wrap is flagged on the increment that takes the count back to zero.
    assign o_wrap  = i_inc && (r_count_q == C_LAST);
    assign o_count = r_count_q;

    always_comb begin
        w_count_d = r_count_q;
        if (i_clr) begin
            w_count_d = '0;
        end else if (i_inc) begin
            w_count_d = o_wrap ? '0 : r_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/chaos_serial_loader.sv
// ============================================================================
// Module  : chaos_serial_loader
// Brief   : Command-driven load/read/restore controller for the chaos chain.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module chaos_serial_loader
    import chaos_loader_pkg::*;
#(
    parameter  int XSIZE  = 20,
    parameter  int YSIZE  = 20,
    parameter  int CW     = CW_DEFAULT,
    localparam int NCELLS = XSIZE * YSIZE,
    localparam int AW     = $clog2(NCELLS)
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [CW-1:0] cmd_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [CW-1:0] rsp_data,
    output logic          chain_shift,
    output logic [CW-1:0] chain_din,
    input  logic [CW-1:0] chain_dout,
    output logic          array_hold,
    output logic [AW-1:0] offset,
    output logic          busy,
    output logic          done
);

    state_t        r_state_q,       w_state_d;
    logic          r_is_read_q,     w_is_read_d;
    logic [CW-1:0] r_data_q,        w_data_d;
    logic          r_cmd_ready_q,   w_cmd_ready_d;
    logic          r_rsp_valid_q,   w_rsp_valid_d;
    logic [CW-1:0] r_rsp_data_q,    w_rsp_data_d;
    logic          r_chain_shift_q, w_chain_shift_d;
    logic          r_array_hold_q,  w_array_hold_d;
    logic          r_busy_q,        w_busy_d;
    logic          r_done_q,        w_done_d;

    logic          w_accept;
    logic          w_wrap;
    logic [AW-1:0] w_offset;

    assign w_accept = cmd_valid && r_cmd_ready_q;

    // The counter advances on exactly the cycles the chain does.
    chaos_offset_counter #(
        .NCELLS (NCELLS),
        .AW     (AW)
    ) u_offset (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .i_inc   (r_chain_shift_q),
        .i_clr   (1'b0),
        .o_count (w_offset),
        .o_wrap  (w_wrap)
    );

    always_comb begin
        w_state_d       = r_state_q;
        w_is_read_d     = r_is_read_q;
        w_data_d        = r_data_q;
        w_cmd_ready_d   = 1'b0;
        w_rsp_valid_d   = 1'b0;
        w_rsp_data_d    = r_rsp_data_q;
        w_chain_shift_d = 1'b0;
        w_array_hold_d  = r_array_hold_q;
        w_done_d        = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                w_cmd_ready_d = 1'b1;
                if (w_accept) begin
                    case (cmd_op)
                        OP_LOAD, OP_READ: begin
                            w_is_read_d     = (cmd_op == OP_READ);
                            w_data_d        = cmd_data;
                            w_array_hold_d  = 1'b1;
                            w_chain_shift_d = 1'b1;
                            w_cmd_ready_d   = 1'b0;
                            w_state_d       = S_SHIFT;
                        end
                        OP_FINISH: begin
                            w_cmd_ready_d = 1'b0;
                            w_state_d     = S_FINISH;
                        end
                        default: ;
                    endcase
                end
            end
            S_SHIFT: begin
                if (r_is_read_q) begin
                    w_rsp_data_d  = chain_dout;
                    w_rsp_valid_d = 1'b1;
                    w_state_d     = S_RSP;
                end else begin
                    w_cmd_ready_d = 1'b1;
                    w_state_d     = S_IDLE;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    w_cmd_ready_d = 1'b1;
                    w_state_d     = S_IDLE;
                end else begin
                    w_rsp_valid_d = 1'b1;
                end
            end
            S_FINISH: begin
                // First FINISH cycle only decides; later cycles rotate until wrap.
                if (r_chain_shift_q ? w_wrap : (w_offset == '0)) begin
                    w_done_d  = 1'b1;
                    w_state_d = S_DONE;
                end else begin
                    w_chain_shift_d = 1'b1;
                end
            end
            S_DONE: begin
                w_array_hold_d = 1'b0;
                w_cmd_ready_d  = 1'b1;
                w_state_d      = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        w_busy_d = (w_state_d != S_IDLE);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state_q       <= S_IDLE;
            r_is_read_q     <= 1'b0;
            r_data_q        <= '0;
            r_cmd_ready_q   <= 1'b0;
            r_rsp_valid_q   <= 1'b0;
            r_rsp_data_q    <= '0;
            r_chain_shift_q <= 1'b0;
            r_array_hold_q  <= 1'b0;
            r_busy_q        <= 1'b0;
            r_done_q        <= 1'b0;
        end else begin
            r_state_q       <= w_state_d;
            r_is_read_q     <= w_is_read_d;
            r_data_q        <= w_data_d;
            r_cmd_ready_q   <= w_cmd_ready_d;
            r_rsp_valid_q   <= w_rsp_valid_d;
            r_rsp_data_q    <= w_rsp_data_d;
            r_chain_shift_q <= w_chain_shift_d;
            r_array_hold_q  <= w_array_hold_d;
            r_busy_q        <= w_busy_d;
            r_done_q        <= w_done_d;
        end
    end

    // A LOAD shift injects the latched word; every other shift rotates the tail back in.
    assign chain_din   = !r_chain_shift_q ? '0 :
                         ((r_state_q == S_SHIFT) && !r_is_read_q) ? r_data_q : chain_dout;
    assign cmd_ready   = r_cmd_ready_q;
    assign rsp_valid   = r_rsp_valid_q;
    assign rsp_data    = r_rsp_data_q;
    assign chain_shift = r_chain_shift_q;
    assign array_hold  = r_array_hold_q;
    assign offset      = w_offset;
    assign busy        = r_busy_q;
    assign done        = r_done_q;

endmodule

`default_nettype wire

// File: tb/tb_chaos_serial_loader.sv
// ============================================================================
// Module  : tb_chaos_serial_loader
// Brief   : Directed bench for chaos_serial_loader with a 400-cell chain model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_chaos_serial_loader;

    localparam int NC = 400;
    localparam logic [31:0] C_WORD = 32'h12569ADE;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        chain_shift;
    logic [31:0] chain_din;
    logic [31:0] chain_dout;
    logic        array_hold;
    logic [8:0]  offset;
    logic        busy;
    logic        done;

    logic [31:0] chain [0:NC-1];
    int          n_cmp;
    int          n_err;
    int          shift_cnt;
    int          timeouts;

    chaos_serial_loader #(
        .XSIZE (20),
        .YSIZE (20),
        .CW    (32)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_data    (cmd_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .chain_shift (chain_shift),
        .chain_din   (chain_din),
        .chain_dout  (chain_dout),
        .array_hold  (array_hold),
        .offset      (offset),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign chain_dout = chain[NC-1];

    always @(posedge clk) begin
        if (chain_shift) begin
            for (int i = NC - 1; i > 0; i--) chain[i] <= chain[i-1];
            chain[0]  <= chain_din;
            shift_cnt <= shift_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [31:0] data);
        int n;
        n         = 0;
        cmd_op    = op;
        cmd_data  = data;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) timeouts++;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'd3;
    endtask

    task automatic do_read(output logic [31:0] word);
        int n;
        n = 0;
        send_cmd(2'd1, 32'h0);
        while (rsp_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) timeouts++;
        word = rsp_data;
        tick();
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) timeouts++;
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] first;
        int          bad;
        int          n;
        int          s0;
        logic [31:0] held;

        for (int i = 0; i < NC; i++) chain[i] = '0;
        n_cmp     = 0;
        n_err     = 0;
        shift_cnt = 0;
        timeouts  = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd3;
        cmd_data  = '0;
        rsp_ready = 1'b1;

        repeat (3) tick();
        check("rst_outputs", {cmd_ready, rsp_valid, chain_shift, array_hold, busy, done, offset, rsp_data}, 64'h0);
        rst = 1'b0;
        repeat (10) tick();
        check("idle_cmd_ready", cmd_ready, 1);
        check("idle_quiet", {rsp_valid, chain_shift, array_hold, busy, done, offset}, 0);
        check("idle_no_shift", shift_cnt, 0);

        send_cmd(2'd3, 32'h0);
        check("nop_ignored", {cmd_ready, busy, chain_shift}, 3'b100);

        send_cmd(2'd0, C_WORD);
        check("load_shift_pulse", chain_shift, 1);
        check("load_hold", array_hold, 1);
        tick();
        check("load_offset", offset, 1);
        check("load_no_rsp_one_shift", {rsp_valid, chain_shift, 32'(shift_cnt)}, {2'b00, 32'd1});
        check("load_head_word", chain[0], C_WORD);

        bad = 0;
        for (int i = 0; i < NC - 1; i++) begin
            do_read(w);
            if (w !== 32'h0) bad++;
        end
        check("reads_1_399_zero", bad, 0);
        do_read(w);
        check("read_400_word", w, C_WORD);
        check("read_400_offset", offset, 1);

        s0 = shift_cnt;
        send_cmd(2'd2, 32'h0);
        wait_done(n);
        check("finish1_latency", n, 400);
        check("finish1_shifts", shift_cnt - s0, 399);
        tick();
        check("finish1_after", {done, array_hold, busy, offset}, 0);
        check("finish1_ready", cmd_ready, 1);

        bad = 0;
        first = '1;
        for (int i = 0; i < NC; i++) begin
            do_read(w);
            if (i == 0) first = w;
            else if (w !== 32'h0) bad++;
        end
        check("home_first_read", first, C_WORD);
        check("home_other_reads", bad, 0);
        check("home_offset", offset, 0);

        s0 = shift_cnt;
        send_cmd(2'd2, 32'h0);
        wait_done(n);
        check("finish0_latency", n, 1);
        check("finish0_no_shift", shift_cnt - s0, 0);
        tick();
        check("finish0_hold_clr", array_hold, 0);

        rsp_ready = 1'b0;
        send_cmd(2'd1, 32'h0);
        tick();
        s0   = shift_cnt;
        held = rsp_data;
        bad  = 0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid !== 1'b1 || rsp_data !== held || cmd_ready !== 1'b0) bad++;
            tick();
        end
        check("bp_stable", bad, 0);
        check("bp_data", held, C_WORD);
        check("bp_no_extra_shift", shift_cnt - s0, 0);
        rsp_ready = 1'b1;
        tick();
        check("bp_release", {rsp_valid, cmd_ready}, 2'b01);
        check("bp_offset", offset, 1);

        send_cmd(2'd2, 32'h0);
        n = 0;
        while (offset !== 9'd200 && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) timeouts++;
        check("midfin_shifting", {chain_shift, busy, array_hold}, 3'b111);
        rst = 1'b1;
        tick();
        check("midfin_reset", {offset, array_hold, busy, chain_shift, done, cmd_ready}, 0);
        rst = 1'b0;
        tick();
        check("midfin_recover", {cmd_ready, busy, offset}, {2'b10, 9'd0});

        check("no_timeouts", timeouts, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
